vga_controller: RTL and testbench

//  Free-running 640x480@60Hz VGA timing generator and renderer for the board display path.

---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_timing.sv | 67 ++++++
 rtl/vga_controller.sv | 109 ++++++++++
 tb/tb_vga_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60Hz timing constants, colour type and the per-axis
// dot bounce step shared by the VGA controller files.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t GRID_COLOR = 12'h444;

  // Direction of travel on one axis; this is the state of the bounce FSM.
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
  } axis_t;

  // One frame step on one axis. Sums are taken at 11 bits so pos+step never
  // wraps; hitting a wall clamps to the wall and flips direction.
  function automatic axis_t axis_step(axis_t cur, logic [10:0] limit, logic [10:0] step);
    axis_t nxt;
    nxt = cur;
    if (cur.dir == DIR_POS) begin
      if ({1'b0, cur.pos} + step > limit) begin
        nxt.pos = limit[9:0];
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = cur.pos + step[9:0];
      end
    end else begin
      if ({1'b0, cur.pos} < step) begin
        nxt.pos = '0;
        nxt.dir = DIR_POS;
      end else begin
        nxt.pos = cur.pos - step[9:0];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: divide-by-4 pixel strobe, h/v raster counters, raw (unregistered)
// syncs, visible-area flag and a once-per-frame pulse for the dot update.
// Timing defaults come from vga_pkg; they are parameters so smaller rasters
// can be built from the same logic.
module vga_timing import vga_pkg::*; #(
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible,
  output logic       frame_end
);

  localparam int H_TOT = H_VIS + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOT = V_VIS + V_FRONT + V_PULSE + V_BACK;

  logic [1:0]  divider;
  logic [10:0] h11, v11;

  assign h11 = {1'b0, h_cnt};
  assign v11 = {1'b0, v_cnt};

  // Free-running clk/4 divider; the pixel strobe is its terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) divider <= '0;
    else        divider <= divider + 2'd1;
  end

  assign pix_tick = (divider == 2'd3);

  // Raster counters: h wraps at line end and carries into v.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == 10'(H_TOT - 1)) begin
        h_cnt <= '0;
        if (v_cnt == 10'(V_TOT - 1)) v_cnt <= '0;
        else                         v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign hsync_raw = !(h11 >= 11'(H_VIS + H_FRONT) && h11 < 11'(H_VIS + H_FRONT + H_PULSE));
  assign vsync_raw = !(v11 >= 11'(V_VIS + V_FRONT) && v11 < 11'(V_VIS + V_FRONT + V_PULSE));
  assign visible   = (h11 < 11'(H_VIS)) && (v11 < 11'(V_VIS));

  // End of the line after the last visible row: the dot moves here so it is
  // never redrawn half-way through a visible frame.
  assign frame_end = pix_tick && (h_cnt == 10'(H_TOT - 1)) && (v_cnt == 10'(V_VIS - 1));

endmodule

// File: rtl/vga_controller.sv
// vga_controller: 640x480@60Hz VGA generator drawing one bouncing square dot.
// Optional build macro VGA_GRID_EN overlays a grey 32-pixel grid behind the dot.
// Outputs are registered on the pixel strobe, one pixel period behind the counters.
module vga_controller import vga_pkg::*; #(
  parameter int     DOT_SIZE  = 8,
  parameter int     START_X   = 100,
  parameter int     START_Y   = 50,
  parameter int     DOT_STEP  = 1,
  parameter rgb12_t DOT_COLOR = 12'hFFF,
  parameter int     H_VIS     = H_VISIBLE,
  parameter int     H_FRONT   = H_FP,
  parameter int     H_PULSE   = H_SYNC,
  parameter int     H_BACK    = H_BP,
  parameter int     V_VIS     = V_VISIBLE,
  parameter int     V_FRONT   = V_FP,
  parameter int     V_PULSE   = V_SYNC,
  parameter int     V_BACK    = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hSync,
  output logic       vSync,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B
);

  logic       pix_tick, hsync_raw, vsync_raw, visible, frame_end;
  logic [9:0] h_cnt, v_cnt;

  vga_timing #(
    .H_VIS(H_VIS), .H_FRONT(H_FRONT), .H_PULSE(H_PULSE), .H_BACK(H_BACK),
    .V_VIS(V_VIS), .V_FRONT(V_FRONT), .V_PULSE(V_PULSE), .V_BACK(V_BACK)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_tick  (pix_tick),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .visible   (visible),
    .frame_end (frame_end)
  );

  axis_t ax_x, ax_y, ax_x_nxt, ax_y_nxt;

  // Dot position/direction register (bounce FSM state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ax_x <= '{pos: 10'(START_X), dir: DIR_POS};
      ax_y <= '{pos: 10'(START_Y), dir: DIR_POS};
    end else begin
      ax_x <= ax_x_nxt;
      ax_y <= ax_y_nxt;
    end
  end

  // Bounce next-state: both axes step independently once per frame.
  always_comb begin
    ax_x_nxt = ax_x;
    ax_y_nxt = ax_y;
    if (frame_end) begin
      ax_x_nxt = axis_step(ax_x, 11'(H_VIS - DOT_SIZE), 11'(DOT_STEP));
      ax_y_nxt = axis_step(ax_y, 11'(V_VIS - DOT_SIZE), 11'(DOT_STEP));
    end
  end

  logic [10:0] h11, v11, x11, y11;
  logic        in_dot;
  rgb12_t      pix_color, rgb;

  assign h11 = {1'b0, h_cnt};
  assign v11 = {1'b0, v_cnt};
  assign x11 = {1'b0, ax_x.pos};
  assign y11 = {1'b0, ax_y.pos};

  assign in_dot = (h11 >= x11) && (h11 < x11 + 11'(DOT_SIZE)) &&
                  (v11 >= y11) && (v11 < y11 + 11'(DOT_SIZE));

  // Pixel colour for the current counters; blanking forces black.
  always_comb begin
    pix_color = '0;
    if (visible) begin
      if (in_dot) pix_color = DOT_COLOR;
`ifdef VGA_GRID_EN
      else if (h_cnt[4:0] == 5'd0 || v_cnt[4:0] == 5'd0) pix_color = GRID_COLOR;
`endif
    end
  end

  // Output registers: sync and colour sampled together so they stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      rgb   <= '0;
    end else if (pix_tick) begin
      hSync <= hsync_raw;
      vSync <= vsync_raw;
      rgb   <= pix_color;
    end
  end

  assign VGA_R = rgb[11:8];
  assign VGA_G = rgb[7:4];
  assign VGA_B = rgb[3:0];

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: directed checks of a full-size instance (line timing) and
// two reduced-raster instances (80x30 total, 64x24 visible) that reach dot
// motion, bounce and frame timing in a few tens of thousands of clocks.
module tb_vga_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic f_hs, f_vs, s_hs, s_vs, e_hs, e_vs;
  logic [3:0] f_r, f_g, f_b, s_r, s_g, s_b, e_r, e_g, e_b;

  vga_controller dut_full (
    .clk(clk), .reset(rst_n), .hSync(f_hs), .vSync(f_vs),
    .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b));

  vga_controller #(
    .H_VIS(64), .H_FRONT(4), .H_PULSE(8), .H_BACK(4),
    .V_VIS(24), .V_FRONT(2), .V_PULSE(2), .V_BACK(2),
    .START_X(20), .START_Y(5)
  ) dut_small (
    .clk(clk), .reset(rst_n), .hSync(s_hs), .vSync(s_vs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b));

  // Starts pressed into the bottom-right corner: both axes bounce together.
  vga_controller #(
    .H_VIS(64), .H_FRONT(4), .H_PULSE(8), .H_BACK(4),
    .V_VIS(24), .V_FRONT(2), .V_PULSE(2), .V_BACK(2),
    .START_X(56), .START_Y(16)
  ) dut_edge (
    .clk(clk), .reset(rst_n), .hSync(e_hs), .vSync(e_vs),
    .VGA_R(e_r), .VGA_G(e_g), .VGA_B(e_b));

  // Clock edges since reset release, matching the DUT's view of time.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    int          fr;
    int          v;
    int          h;
    logic [11:0] ex;
  } vec_t;

  // Pixel p (small raster, 2400 px/frame) is driven from edge 4(p+1); sample one edge later.
  function automatic int unsigned pcyc(int fr, int v, int h);
    return 4 * (fr * 2400 + v * 80 + h) + 5;
  endfunction

  function automatic logic [11:0] rgb_of(int sel);
    case (sel)
      0:       return {f_r, f_g, f_b};
      1:       return {s_r, s_g, s_b};
      default: return {e_r, e_g, e_b};
    endcase
  endfunction

  function automatic logic [13:0] outs_of(int sel);
    case (sel)
      0:       return {f_hs, f_vs, f_r, f_g, f_b};
      1:       return {s_hs, s_vs, s_r, s_g, s_b};
      default: return {e_hs, e_vs, e_r, e_g, e_b};
    endcase
  endfunction

  task automatic wait_cyc(int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [13:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = outs_of(i);
      checks++;
      if (got !== 14'h3000) begin
        failures++;
        $display("FAIL reset_idle inst=%0d outs=%h expected=%h", i, got, 14'h3000);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame;
    vec_t tbl [8];
    logic [11:0] got;
    tbl = '{'{1, 0, 4, 20, 12'h000}, '{1, 0, 5, 19, 12'h000},
            '{1, 0, 5, 20, 12'hFFF}, '{1, 0, 5, 28, 12'h000},
            '{1, 0, 12, 27, 12'hFFF}, '{1, 0, 13, 27, 12'h000},
            '{2, 0, 23, 63, 12'hFFF}, '{2, 0, 23, 64, 12'h000}};
    foreach (tbl[i]) begin
      wait_cyc(pcyc(tbl[i].fr, tbl[i].v, tbl[i].h));
      got = rgb_of(tbl[i].sel);
      checks++;
      if (got !== tbl[i].ex) begin
        failures++;
        $display("FAIL first_frame inst=%0d v=%0d h=%0d rgb=%h expected=%h",
                 tbl[i].sel, tbl[i].v, tbl[i].h, got, tbl[i].ex);
      end
    end
  endtask

  task automatic test_line_timing;
    int unsigned lim, t_fall, t_rise, t_next;
    lim = cyc + 10000;
    while (f_hs !== 1'b1 && cyc < lim) @(negedge clk);
    while (f_hs !== 1'b0 && cyc < lim) @(negedge clk);
    t_fall = cyc;
    while (f_hs !== 1'b1 && cyc < lim) @(negedge clk);
    t_rise = cyc;
    while (f_hs !== 1'b0 && cyc < lim) @(negedge clk);
    t_next = cyc;
    checks++;
    if (t_fall % 3200 != 2628) begin
      failures++;
      $display("FAIL hsync_phase fall_cyc_mod=%0d expected=2628", t_fall % 3200);
    end
    checks++;
    if (t_rise - t_fall != 384) begin
      failures++;
      $display("FAIL hsync_low_width got=%0d expected=384", t_rise - t_fall);
    end
    checks++;
    if (t_next - t_fall != 3200) begin
      failures++;
      $display("FAIL hsync_period got=%0d expected=3200", t_next - t_fall);
    end
  endtask

  task automatic test_motion;
    vec_t tbl [6];
    logic [11:0] got;
    // Frame 1: small dot at (21,6); edge dot clamped at (56,16), now heading back.
    tbl = '{'{1, 1, 13, 20, 12'h000}, '{1, 1, 13, 28, 12'hFFF},
            '{1, 1, 13, 29, 12'h000}, '{1, 1, 14, 28, 12'h000},
            '{2, 1, 16, 55, 12'h000}, '{2, 1, 16, 56, 12'hFFF}};
    foreach (tbl[i]) begin
      wait_cyc(pcyc(tbl[i].fr, tbl[i].v, tbl[i].h));
      got = rgb_of(tbl[i].sel);
      checks++;
      if (got !== tbl[i].ex) begin
        failures++;
        $display("FAIL motion inst=%0d v=%0d h=%0d rgb=%h expected=%h",
                 tbl[i].sel, tbl[i].v, tbl[i].h, got, tbl[i].ex);
      end
    end
  endtask

  task automatic test_frame_timing;
    int unsigned lim, t_fall, t_rise, t_next;
    lim = cyc + 25000;
    while (s_vs !== 1'b0 && cyc < lim) @(negedge clk);
    t_fall = cyc;
    while (s_vs !== 1'b1 && cyc < lim) @(negedge clk);
    t_rise = cyc;
    while (s_vs !== 1'b0 && cyc < lim) @(negedge clk);
    t_next = cyc;
    checks++;
    if (t_fall != 17924) begin
      failures++;
      $display("FAIL vsync_fall got=%0d expected=17924", t_fall);
    end
    checks++;
    if (t_rise - t_fall != 640) begin
      failures++;
      $display("FAIL vsync_low_width got=%0d expected=640", t_rise - t_fall);
    end
    checks++;
    if (t_next - t_fall != 9600) begin
      failures++;
      $display("FAIL vsync_period got=%0d expected=9600", t_next - t_fall);
    end
  endtask

  task automatic test_bounce;
    vec_t tbl [4];
    logic [11:0] got;
    // Frame 3: corner dot has retreated two steps on both axes, to (54,14).
    tbl = '{'{2, 3, 14, 53, 12'h000}, '{2, 3, 14, 54, 12'hFFF},
            '{2, 3, 21, 61, 12'hFFF}, '{2, 3, 21, 62, 12'h000}};
    foreach (tbl[i]) begin
      wait_cyc(pcyc(tbl[i].fr, tbl[i].v, tbl[i].h));
      got = rgb_of(tbl[i].sel);
      checks++;
      if (got !== tbl[i].ex) begin
        failures++;
        $display("FAIL bounce inst=%0d v=%0d h=%0d rgb=%h expected=%h",
                 tbl[i].sel, tbl[i].v, tbl[i].h, got, tbl[i].ex);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [13:0] got;
    // Frame 4 small dot at (24,9) is lit; full-size instance is inside its hsync pulse.
    wait_cyc(pcyc(4, 9, 24));
    checks++;
    if ({s_r, s_g, s_b} !== 12'hFFF || f_hs !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_active small_rgb=%h full_hs=%b expected=fff/0",
               {s_r, s_g, s_b}, f_hs);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      got = outs_of(i);
      checks++;
      if (got !== 14'h3000) begin
        failures++;
        $display("FAIL mid_reset_idle inst=%0d outs=%h expected=%h", i, got, 14'h3000);
      end
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_restart;
    int unsigned lim;
    logic [11:0] got;
    wait_cyc(pcyc(0, 5, 19));
    got = {s_r, s_g, s_b};
    checks++;
    if (got !== 12'h000) begin
      failures++;
      $display("FAIL restart_px19_5 rgb=%h expected=000", got);
    end
    wait_cyc(pcyc(0, 5, 20));
    got = {s_r, s_g, s_b};
    checks++;
    if (got !== 12'hFFF) begin
      failures++;
      $display("FAIL restart_px20_5 rgb=%h expected=fff", got);
    end
    lim = cyc + 5000;
    while (f_hs !== 1'b0 && cyc < lim) @(negedge clk);
    checks++;
    if (cyc != 2628) begin
      failures++;
      $display("FAIL restart_hsync_fall got=%0d expected=2628", cyc);
    end
    wait_cyc(pcyc(0, 16, 56));
    got = {e_r, e_g, e_b};
    checks++;
    if (got !== 12'hFFF) begin
      failures++;
      $display("FAIL restart_edge_px56_16 rgb=%h expected=fff", got);
    end
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_line_timing;
    test_motion;
    test_frame_timing;
    test_bounce;
    test_reset_mid;
    test_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
